// File: rtl/multi_obj_mover_pkg.sv
// -----------------------------------------------------------------------------
// multi_obj_mover_pkg
// Shared constants for the object mover slice:
//   - display extents and the sync pipeline delay used by the timing and
//     generator blocks (the leftmost drawable x sits one short of SYNC_DLY)
//   - acceleration FSM state codes
//   - small width helpers used to size selector, step and hold counters
// -----------------------------------------------------------------------------
package multi_obj_mover_pkg;

    localparam int SYNC_DLY = 3;
    localparam int DISP_W   = 640;
    localparam int DISP_H   = 480;

    // Acceleration FSM states
    localparam logic [0:0] ACC_IDLE = 1'b0;
    localparam logic [0:0] ACC_HOLD = 1'b1;

    // A single object still needs a one-bit selector port
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Enough bits to hold the value n itself
    function automatic int hold_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/multi_obj_mover_axis_stepper.sv
// -----------------------------------------------------------------------------
// axis_stepper
// Purely combinational single-axis position update. Moves cur by +/-step
// when exactly one direction is requested, then clamps or wraps the result
// into the legal window [MIN, MAX-1].
// Ports:
//   cur      in  W   current coordinate
//   dir_neg  in  1   request towards MIN
//   dir_pos  in  1   request towards MAX
//   step     in  SW  step magnitude
//   nxt      out W   next coordinate
// -----------------------------------------------------------------------------
module axis_stepper #(
    parameter int W    = 11,
    parameter int SW   = 4,
    parameter int MIN  = 0,
    parameter int MAX  = 640,
    parameter bit WRAP = 1'b0
) (
    input  logic [W-1:0]  cur,
    input  logic          dir_neg,
    input  logic          dir_pos,
    input  logic [SW-1:0] step,
    output logic [W-1:0]  nxt
);

    // Two extra bits: one for sign, one so cur+step can never overflow
    // even when MAX sits at the top of the W-bit range.
    localparam int EW = W + 2;
    localparam logic signed [EW-1:0] MIN_S  = EW'(MIN);
    localparam logic signed [EW-1:0] MAX_S  = EW'(MAX);
    localparam logic signed [EW-1:0] LAST_S = EW'(MAX - 1);
    localparam logic signed [EW-1:0] SPAN_S = EW'(MAX - MIN);

    logic signed [EW-1:0] cur_s;
    logic signed [EW-1:0] step_s;
    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] res;

    assign cur_s  = signed'(EW'(cur));
    assign step_s = signed'(EW'(step));

    // Opposing requests cancel; a stored value outside the window is pulled
    // back to MIN regardless of the requested motion.
    always_comb begin
        sum = cur_s;
        if (dir_neg && !dir_pos) begin
            sum = cur_s - step_s;
        end else if (dir_pos && !dir_neg) begin
            sum = cur_s + step_s;
        end

        if (cur_s < MIN_S || cur_s >= MAX_S) begin
            res = MIN_S;
        end else if (sum < MIN_S) begin
            res = WRAP ? (sum + SPAN_S) : MIN_S;
        end else if (sum >= MAX_S) begin
            res = WRAP ? (sum - SPAN_S) : LAST_S;
        end else begin
            res = sum;
        end
    end

    assign nxt = res[W-1:0];

endmodule

// File: rtl/multi_obj_mover.sv
// -----------------------------------------------------------------------------
// multi_obj_mover
// Holds x/y positions for N_OBJ on-screen objects and steps the selected one
// once per frame (vsync falling edge) from the button levels. Holding a
// direction doubles the step every HOLD_FRAMES frames up to MAX_STEP; home
// sends the selected object back to (X_MIN, Y_MIN).
// Ports:
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   move_en      in   movement enable (0 freezes positions, ignores home)
//   sel          in   index of the object under control
//   up/down/left/right in  debounced button levels
//   home         in   return selected object to (X_MIN, Y_MIN) at next tick
//   vsync        in   vertical sync from the VGA timing block
//   x_pos        out  packed x positions, object i at [i*XW +: XW]
//   y_pos        out  packed y positions, object i at [i*YW +: YW]
//   frame_tick   out  one-cycle pulse after each vsync falling edge
//   moving       out  selected object changed position on the last tick
// -----------------------------------------------------------------------------
module multi_obj_mover
    import multi_obj_mover_pkg::*;
#(
    parameter int N_OBJ       = 4,
    parameter int XW          = 11,
    parameter int YW          = 10,
    parameter int X_MIN       = SYNC_DLY - 1,
    parameter int X_MAX       = DISP_W,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = DISP_H,
    parameter bit WRAP        = 1'b0,
    parameter int HOLD_FRAMES = 8,
    parameter int MAX_STEP    = 8,
    localparam int SEL_W      = sel_width(N_OBJ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  move_en,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  up,
    input  logic                  down,
    input  logic                  left,
    input  logic                  right,
    input  logic                  home,
    input  logic                  vsync,
    output logic [N_OBJ*XW-1:0]   x_pos,
    output logic [N_OBJ*YW-1:0]   y_pos,
    output logic                  frame_tick,
    output logic                  moving
);

    localparam int STEP_W = hold_width(MAX_STEP);
    localparam int CNT_W  = hold_width(HOLD_FRAMES);

    logic                vsync_d;
    logic [SEL_W-1:0]    prev_sel;
    logic [XW-1:0]       x_arr [N_OBJ];
    logic [YW-1:0]       y_arr [N_OBJ];

    logic [0:0]          state, base_state, nstate;
    logic [STEP_W-1:0]   step, base_step, nstep;
    logic [CNT_W-1:0]    cnt, base_cnt, ncnt;

    logic                sel_changed;
    logic                sel_valid;
    logic                any_dir;
    logic [XW-1:0]       cur_x, nxt_x, tgt_x;
    logic [YW-1:0]       cur_y, nxt_y, tgt_y;

    assign sel_changed = (sel != prev_sel);
    assign any_dir     = up | down | left | right;

    // Selected-object read mux; an index beyond N_OBJ selects nothing.
    always_comb begin
        cur_x     = XW'(X_MIN);
        cur_y     = YW'(Y_MIN);
        sel_valid = 1'b0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (sel == SEL_W'(i)) begin
                cur_x     = x_arr[i];
                cur_y     = y_arr[i];
                sel_valid = 1'b1;
            end
        end
    end

    // A selection change restarts acceleration in the same cycle, so a tick
    // coinciding with the change already moves the new object by 1.
    always_comb begin
        if (sel_changed) begin
            base_state = ACC_IDLE;
            base_step  = STEP_W'(1);
            base_cnt   = '0;
        end else begin
            base_state = state;
            base_step  = step;
            base_cnt   = cnt;
        end
    end

    axis_stepper #(
        .W(XW), .SW(STEP_W), .MIN(X_MIN), .MAX(X_MAX), .WRAP(WRAP)
    ) u_step_x (
        .cur(cur_x), .dir_neg(left), .dir_pos(right), .step(base_step), .nxt(nxt_x)
    );

    axis_stepper #(
        .W(YW), .SW(STEP_W), .MIN(Y_MIN), .MAX(Y_MAX), .WRAP(WRAP)
    ) u_step_y (
        .cur(cur_y), .dir_neg(up), .dir_pos(down), .step(base_step), .nxt(nxt_y)
    );

    assign tgt_x = home ? XW'(X_MIN) : nxt_x;
    assign tgt_y = home ? YW'(Y_MIN) : nxt_y;

    // Acceleration: every held tick counts, and the tick that completes
    // HOLD_FRAMES doubles the step for the following ticks.
    always_comb begin
        nstate = base_state;
        nstep  = base_step;
        ncnt   = base_cnt;
        if (!move_en) begin
            nstate = ACC_IDLE;
            nstep  = STEP_W'(1);
            ncnt   = '0;
        end else if (frame_tick) begin
            if (home || !any_dir) begin
                nstate = ACC_IDLE;
                nstep  = STEP_W'(1);
                ncnt   = '0;
            end else begin
                nstate = ACC_HOLD;
                if (base_cnt == CNT_W'(HOLD_FRAMES - 1)) begin
                    ncnt = '0;
                    if (base_step < STEP_W'(MAX_STEP)) begin
                        nstep = base_step << 1;
                    end
                end else begin
                    ncnt = base_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d    <= 1'b0;
            frame_tick <= 1'b0;
            prev_sel   <= '0;
            state      <= ACC_IDLE;
            step       <= STEP_W'(1);
            cnt        <= '0;
            moving     <= 1'b0;
            for (int i = 0; i < N_OBJ; i++) begin
                x_arr[i] <= XW'(X_MIN);
                y_arr[i] <= YW'(Y_MIN);
            end
        end else begin
            vsync_d    <= vsync;
            frame_tick <= vsync_d & ~vsync;
            prev_sel   <= sel;
            state      <= nstate;
            step       <= nstep;
            cnt        <= ncnt;
            if (frame_tick) begin
                moving <= move_en && sel_valid && ((tgt_x != cur_x) || (tgt_y != cur_y));
                if (move_en) begin
                    for (int i = 0; i < N_OBJ; i++) begin
                        if (sel == SEL_W'(i)) begin
                            x_arr[i] <= tgt_x;
                            y_arr[i] <= tgt_y;
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < N_OBJ; g++) begin : g_pack
        assign x_pos[g*XW +: XW] = x_arr[g];
        assign y_pos[g*YW +: YW] = y_arr[g];
    end

endmodule

// File: tb/tb_multi_obj_mover.sv
// -----------------------------------------------------------------------------
// tb_multi_obj_mover
// Drives a clamping and a wrapping instance with the same stimulus and
// compares both against a frame-level integer model of the mover.
// -----------------------------------------------------------------------------
module tb_multi_obj_mover;
    import multi_obj_mover_pkg::*;

    localparam int N    = 4;
    localparam int XMIN = SYNC_DLY - 1;
    localparam int XMAX = 640;
    localparam int YMIN = 0;
    localparam int YMAX = 480;
    localparam int HOLD = 8;
    localparam int MAXS = 8;

    logic clk = 1'b0;
    logic rst_n, move_en, up, down, left, right, home, vsync;
    logic [1:0]    sel;
    logic [N*11-1:0] x_pos_c, x_pos_w;
    logic [N*10-1:0] y_pos_c, y_pos_w;
    logic ft_c, ft_w, mv_c, mv_w;

    int checks = 0;
    int errors = 0;

    // Frame-level model: index 0 = clamp instance, 1 = wrap instance
    int mx [2][N];
    int my [2][N];
    int m_step, m_cnt, m_prev_sel;
    bit m_mov [2];

    always #5 clk = ~clk;

    multi_obj_mover dut_clamp (
        .clk(clk), .rst_n(rst_n), .move_en(move_en), .sel(sel),
        .up(up), .down(down), .left(left), .right(right), .home(home),
        .vsync(vsync), .x_pos(x_pos_c), .y_pos(y_pos_c),
        .frame_tick(ft_c), .moving(mv_c)
    );

    multi_obj_mover #(.WRAP(1'b1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .move_en(move_en), .sel(sel),
        .up(up), .down(down), .left(left), .right(right), .home(home),
        .vsync(vsync), .x_pos(x_pos_w), .y_pos(y_pos_w),
        .frame_tick(ft_w), .moving(mv_w)
    );

    function automatic int get_x(input logic [N*11-1:0] v, input int i);
        return int'(v[i*11 +: 11]);
    endfunction

    function automatic int get_y(input logic [N*10-1:0] v, input int i);
        return int'(v[i*10 +: 10]);
    endfunction

    // One axis move under the clamp/wrap rules
    function automatic int axis(input int cur, input bit neg, input bit pos,
                                input int st, input int lo, input int hi, input bit wrap);
        int v;
        if (cur < lo || cur >= hi) return lo;
        v = cur;
        if (pos && !neg) v = cur + st;
        if (neg && !pos) v = cur - st;
        if (v < lo) return wrap ? v + (hi - lo) : lo;
        if (v >= hi) return wrap ? v - (hi - lo) : hi - 1;
        return v;
    endfunction

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < N; i++) begin
                mx[w][i] = XMIN;
                my[w][i] = YMIN;
            end
            m_mov[w] = 1'b0;
        end
        m_step     = 1;
        m_cnt      = 0;
        m_prev_sel = 0;
    endtask

    task automatic model_tick();
        int s, ox, oy, nx, ny;
        s = int'(sel);
        if (s != m_prev_sel) begin
            m_step = 1;
            m_cnt  = 0;
        end
        m_prev_sel = s;
        if (!move_en) begin
            m_step = 1;
            m_cnt  = 0;
            m_mov[0] = 1'b0;
            m_mov[1] = 1'b0;
            return;
        end
        for (int w = 0; w < 2; w++) begin
            ox = mx[w][s];
            oy = my[w][s];
            if (home) begin
                nx = XMIN;
                ny = YMIN;
            end else begin
                nx = axis(ox, left, right, m_step, XMIN, XMAX, w[0]);
                ny = axis(oy, up, down, m_step, YMIN, YMAX, w[0]);
            end
            m_mov[w] = (nx != ox) || (ny != oy);
            mx[w][s] = nx;
            my[w][s] = ny;
        end
        if (home || !(up || down || left || right)) begin
            m_step = 1;
            m_cnt  = 0;
        end else begin
            m_cnt++;
            if (m_cnt == HOLD) begin
                m_cnt  = 0;
                m_step = (2 * m_step > MAXS) ? MAXS : 2 * m_step;
            end
        end
    endtask

    task automatic check_output();
        for (int i = 0; i < N; i++) begin
            check_int($sformatf("clamp x%0d", i), get_x(x_pos_c, i), mx[0][i]);
            check_int($sformatf("clamp y%0d", i), get_y(y_pos_c, i), my[0][i]);
            check_int($sformatf("wrap x%0d", i), get_x(x_pos_w, i), mx[1][i]);
            check_int($sformatf("wrap y%0d", i), get_y(y_pos_w, i), my[1][i]);
        end
        check_int("clamp moving", int'(mv_c), int'(m_mov[0]));
        check_int("wrap moving", int'(mv_w), int'(m_mov[1]));
    endtask

    task automatic set_btn(input bit u, input bit d, input bit l, input bit r);
        up    = u;
        down  = d;
        left  = l;
        right = r;
    endtask

    // One full frame: vsync high then falling, count tick pulses, update model
    task automatic apply_stimulus();
        int ticks;
        ticks = 0;
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ft_c === 1'b1) ticks++;
        end
        check_int("frame_tick pulses", ticks, 1);
        model_tick();
        check_output();
    endtask

    initial begin
        int ox, oy;
        rst_n   = 1'b0;
        move_en = 1'b1;
        sel     = 2'd0;
        home    = 1'b0;
        vsync   = 1'b0;
        set_btn(0, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_int("reset frame_tick", int'(ft_c), 0);
        check_output();

        // Held right on object 2: 8 ticks at 1, 8 at 2, 4 at 4
        sel = 2'd2;
        set_btn(0, 0, 0, 1);
        repeat (20) apply_stimulus();
        check_int("accel obj2 x", get_x(x_pos_c, 2), XMIN + 40);

        // Keep going into the right edge
        repeat (90) apply_stimulus();
        check_int("clamp edge x", get_x(x_pos_c, 2), XMAX - 1);
        check_int("clamp edge moving", int'(mv_c), 0);

        // Opposing vertical buttons cancel, horizontal still moves
        sel = 2'd0;
        set_btn(0, 0, 0, 0);
        apply_stimulus();
        ox = mx[0][0];
        oy = my[0][0];
        set_btn(1, 1, 0, 1);
        apply_stimulus();
        check_int("cancel y", get_y(y_pos_c, 0), oy);
        check_int("cancel x", get_x(x_pos_c, 0), ox + 1);
        repeat (8) apply_stimulus();
        set_btn(0, 0, 0, 0);
        apply_stimulus();
        ox = mx[0][0];
        set_btn(0, 0, 0, 1);
        apply_stimulus();
        check_int("step back to 1", get_x(x_pos_c, 0), ox + 1);

        // Wrap at the top and bottom edges on a fresh object
        sel = 2'd1;
        set_btn(1, 0, 0, 0);
        apply_stimulus();
        check_int("wrap up y", get_y(y_pos_w, 1), YMAX - 1);
        check_int("clamp up y", get_y(y_pos_c, 1), YMIN);
        set_btn(0, 1, 0, 0);
        apply_stimulus();
        check_int("wrap down y", get_y(y_pos_w, 1), YMIN);
        set_btn(1, 0, 0, 0);
        repeat (20) apply_stimulus();

        // Selection change during acceleration restarts at step 1
        sel = 2'd0;
        set_btn(0, 0, 1, 0);
        repeat (17) apply_stimulus();
        sel = 2'd1;
        ox = mx[0][1];
        apply_stimulus();
        check_int("sel switch step", get_x(x_pos_c, 1), (ox - 1 < XMIN) ? XMIN : ox - 1);
        home = 1'b1;
        apply_stimulus();
        home = 1'b0;
        check_int("home x", get_x(x_pos_c, 1), XMIN);
        check_int("home y", get_y(y_pos_c, 1), YMIN);

        // Disabled: buttons and home ignored
        move_en = 1'b0;
        set_btn(0, 1, 0, 1);
        apply_stimulus();
        home = 1'b1;
        apply_stimulus();
        home    = 1'b0;
        move_en = 1'b1;

        // Randomised frames with sticky buttons
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                set_btn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
            home    = ($urandom_range(0, 15) == 0);
            move_en = ($urandom_range(0, 15) != 0);
            apply_stimulus();
        end
        home    = 1'b0;
        move_en = 1'b1;

        // Asynchronous reset mid-frame, observed before any clock edge
        vsync = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_output();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_btn(0, 1, 0, 0);
        sel = 2'd3;
        repeat (3) apply_stimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
